// File: rtl/logic_gate_checker_if.sv
// Control/status bundle between a self-test requester and logic_gate_checker.
// The failure-log signals exist only when LOGIC_GATE_CHECKER_ERR_LOG_EN is defined.
interface logic_gate_checker_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
    logic [1:0] fail_vec;
    logic [6:0] fail_mask;

    modport master (
        output start,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec,
        input  fail_mask
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec,
        output fail_mask
    );
`else
    modport master (
        output start,
        input  busy,
        input  done,
        input  pass,
        input  err_count
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output pass,
        output err_count
    );
`endif
endinterface

// File: rtl/logic_gate_checker.sv
// On-chip self-test checker: walks (a,b) through 00..11, samples the seven gate outputs
// after a settle time and reports pass/fail. Optional failure log: LOGIC_GATE_CHECKER_ERR_LOG_EN.
module logic_gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_gate_checker_if.slave  ctl,
    output logic                 a,
    output logic                 b,
    input  logic [6:0]           gate_in
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam bit             SKIP_SETTLE = (SETTLE_CYCLES == 32'd0);
    localparam logic [CNT_W-1:0] SETTLE_LAST =
        SKIP_SETTLE ? {CNT_W{1'b0}} : CNT_W'(SETTLE_CYCLES - 32'd1);

    // Bit order 6..0: xnor, xor, nor, nand, not(a), or, and
    function automatic logic [6:0] expected_gates(input logic [1:0] vec);
        logic [6:0] exp_v;
        case (vec)
            2'd0:    exp_v = 7'h5C;
            2'd1:    exp_v = 7'h2E;
            2'd2:    exp_v = 7'h2A;
            2'd3:    exp_v = 7'h43;
            default: exp_v = 7'h00;
        endcase
        return exp_v;
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
        logic [2:0] res_v;
        if (cnt >= 3'd4) begin
            res_v = 3'd4;
        end else begin
            res_v = cnt + 3'd1;
        end
        return res_v;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic             a_r;
    logic             b_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [2:0]       err_r;
    logic [6:0]       diff_s;
    logic             mismatch_s;
    logic             settle_last_s;
    logic             accept_s;

    // Mismatch detection and handshake qualification
    always_comb begin
        diff_s        = gate_in ^ expected_gates(idx_r);
        mismatch_s    = (diff_s != 7'h00);
        settle_last_s = (cnt_r == SETTLE_LAST);
        accept_s      = 1'b0;
        if (state_r == IDLE) begin
            accept_s = ctl.start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ctl.start) begin
                    state_s = APPLY;
                end else begin
                    state_s = IDLE;
                end
            end
            APPLY: begin
                if (SKIP_SETTLE) begin
                    state_s = CHECK;
                end else begin
                    state_s = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_last_s) begin
                    state_s = CHECK;
                end else begin
                    state_s = SETTLE;
                end
            end
            CHECK: begin
                if (idx_r == 2'd3) begin
                    state_s = DONE;
                end else begin
                    state_s = APPLY;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Vector index and stimulus outputs; a,b keep the last vector between passes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= 2'd0;
            a_r   <= 1'b0;
            b_r   <= 1'b0;
        end else if (accept_s) begin
            idx_r <= 2'd0;
        end else if (state_r == APPLY) begin
            a_r <= idx_r[1];
            b_r <= idx_r[0];
        end else if ((state_r == CHECK) && (idx_r != 2'd3)) begin
            idx_r <= idx_r + 2'd1;
        end
    end

    // Settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == APPLY) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == SETTLE) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Error count and pass verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r  <= 3'd0;
            pass_r <= 1'b0;
        end else if (accept_s) begin
            err_r  <= 3'd0;
            pass_r <= 1'b0;
        end else if ((state_r == CHECK) && mismatch_s) begin
            err_r <= sat_inc(err_r);
        end else if (state_r == DONE) begin
            pass_r <= (err_r == 3'd0);
        end
    end

    // Busy and done status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == DONE);
        end
    end

`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
    logic [1:0] fail_vec_r;
    logic [6:0] fail_mask_r;

    // First-failure log; an error count of zero marks the first mismatch of the pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vec_r  <= 2'd0;
            fail_mask_r <= 7'h00;
        end else if (accept_s) begin
            fail_vec_r  <= 2'd0;
            fail_mask_r <= 7'h00;
        end else if ((state_r == CHECK) && mismatch_s && (err_r == 3'd0)) begin
            fail_vec_r  <= idx_r;
            fail_mask_r <= diff_s;
        end
    end

    assign ctl.fail_vec  = fail_vec_r;
    assign ctl.fail_mask = fail_mask_r;
`endif

    assign a             = a_r;
    assign b             = b_r;
    assign ctl.busy      = busy_r;
    assign ctl.done      = done_r;
    assign ctl.pass      = pass_r;
    assign ctl.err_count = err_r;

endmodule

// File: tb/tb_logic_gate_checker.sv
// Directed bench for logic_gate_checker: two instances (settle 2 and settle 0) driving a
// behavioural gate model with injectable faults; expectations queued at start, checked at done.
module tb_logic_gate_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_drv;
    logic sel;
    int   fault;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    typedef struct {
        logic [2:0] err;
        logic       pass;
        logic [1:0] fvec;
        logic [6:0] fmask;
        int         lat;
    } res_t;

    res_t       res_q[$];
    logic [1:0] vec_q[$];

    logic_gate_checker_if if0 ();
    logic_gate_checker_if if1 ();

    logic       a0, b0, a1, b1;
    logic [6:0] g0, g1;

    function automatic logic [6:0] ref_gates(input logic ia, input logic ib);
        return {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ~ia, ia | ib, ia & ib};
    endfunction

    function automatic logic [6:0] faulty_gates(input logic ia, input logic ib, input int mode);
        logic [6:0] g;
        g = ref_gates(ia, ib);
        if (mode == 1) g[0] = 1'b1;
        else if (mode == 2) g[6] = ~g[6];
        return g;
    endfunction

    always_comb g0 = faulty_gates(a0, b0, fault);
    always_comb g1 = faulty_gates(a1, b1, fault);

    assign if0.start = start_drv & ~sel;
    assign if1.start = start_drv & sel;

    logic_gate_checker #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ctl(if0), .a(a0), .b(b0), .gate_in(g0));

    logic_gate_checker #(.SETTLE_CYCLES(0), .CNT_W(4)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .ctl(if1), .a(a1), .b(b1), .gate_in(g1));

    logic       o_a, o_b, o_busy, o_done, o_pass;
    logic [2:0] o_err;
    logic [1:0] o_fvec;
    logic [6:0] o_fmask;

    always_comb begin
        o_fvec  = 2'd0;
        o_fmask = 7'h00;
        if (sel) begin
            o_a = a1; o_b = b1; o_busy = if1.busy; o_done = if1.done;
            o_pass = if1.pass; o_err = if1.err_count;
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
            o_fvec = if1.fail_vec; o_fmask = if1.fail_mask;
`endif
        end else begin
            o_a = a0; o_b = b0; o_busy = if0.busy; o_done = if0.done;
            o_pass = if0.pass; o_err = if0.err_count;
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
            o_fvec = if0.fail_vec; o_fmask = if0.fail_mask;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input int mode, input int lat);
        res_t       r;
        logic [1:0] v;
        logic [6:0] t;
        logic [6:0] f;
        r.err = 3'd0; r.fvec = 2'd0; r.fmask = 7'h00; r.lat = lat;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            t = ref_gates(v[1], v[0]);
            f = faulty_gates(v[1], v[0], mode);
            if (f !== t) begin
                if (r.err == 3'd0) begin
                    r.fvec  = v;
                    r.fmask = f ^ t;
                end
                if (r.err < 3'd4) r.err = r.err + 3'd1;
            end
        end
        r.pass = (r.err == 3'd0);
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ab"},   {30'd0, o_a, o_b}, 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, o_done}, 32'd0);
        check({tag, "_pass"}, {31'd0, o_pass}, 32'd0);
        check({tag, "_err"},  {29'd0, o_err}, 32'd0);
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
        check({tag, "_fvec"},  {30'd0, o_fvec}, 32'd0);
        check({tag, "_fmask"}, {25'd0, o_fmask}, 32'd0);
`endif
    endtask

    // One check pass: optional start re-pulses (probe) or a reset at cycle abort_at.
    task automatic run_pass(input int s_cycles, input int mode, input bit probe, input int abort_at);
        int         per;
        int         lat_exp;
        int         cyc;
        bit         seen;
        res_t       r;
        logic [1:0] v;
        per     = s_cycles + 2;
        lat_exp = 4 * per;
        fault   = mode;
        res_q.push_back(model(mode, lat_exp));
        for (int i = 0; i < 4; i++) vec_q.push_back(2'(i));
        @(negedge clk);
        start_drv = 1'b1;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && (cyc < lat_exp + 8)) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start_drv = 1'b0;
                check("busy_on_accept", {31'd0, o_busy}, 32'd1);
                check("err_cleared", {29'd0, o_err}, 32'd0);
                check("pass_cleared", {31'd0, o_pass}, 32'd0);
            end
            if (probe && (cyc == 5)) start_drv = 1'b1;
            else if (probe && (cyc == 6)) start_drv = 1'b0;
            if ((cyc >= 2) && (((cyc - 2) % per) == 0) && (vec_q.size() > 0)) begin
                v = vec_q.pop_front();
                check("ab_vector", {30'd0, o_a, o_b}, {30'd0, v});
            end
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                rst_n = 1'b1;
                vec_q.delete();
                res_q.delete();
                return;
            end
            if (o_done) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (!seen) begin
            vec_q.delete();
            res_q.delete();
            return;
        end
        r = res_q.pop_front();
        check("latency", cyc - 1, r.lat);
        check("err_count", {29'd0, o_err}, {29'd0, r.err});
`ifdef LOGIC_GATE_CHECKER_ERR_LOG_EN
        check("fail_vec", {30'd0, o_fvec}, {30'd0, r.fvec});
        check("fail_mask", {25'd0, o_fmask}, {25'd0, r.fmask});
`endif
        if (probe) start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        check("done_single", {31'd0, o_done}, 32'd0);
        check("busy_off", {31'd0, o_busy}, 32'd0);
        check("pass", {31'd0, o_pass}, {31'd0, r.pass});
        check("ab_hold", {30'd0, o_a, o_b}, 32'd3);
        if (probe) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("no_queued_start", {30'd0, o_busy, o_done}, 32'd0);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start_drv = 1'b0;
        sel       = 1'b0;
        fault     = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_s2");
        sel = 1'b1;
        #1;
        check_reset_outputs("reset_s0");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_pass(2, 0, 1'b0, 0);
        run_pass(2, 1, 1'b0, 0);
        run_pass(2, 0, 1'b1, 0);
        run_pass(2, 2, 1'b0, 0);
        run_pass(2, 0, 1'b0, 10);
        run_pass(2, 0, 1'b0, 0);

        sel = 1'b1;
        run_pass(0, 0, 1'b0, 0);
        run_pass(0, 2, 1'b0, 0);
        run_pass(0, 0, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
